// File: rtl/pitch_sched_pkg.sv
// ---------------------------------------------------------------------------
// pitch_sched_pkg
// Shared definitions for the pitch frame scheduler:
//   - sched_state_t : scheduler FSM states
//   - PITCH_*       : 16.16 fixed-point pitch word layout
// ---------------------------------------------------------------------------
package pitch_sched_pkg;

    localparam int PITCH_INT_BITS  = 16;
    localparam int PITCH_FRAC_BITS = 16;
    localparam int PITCH_WIDTH     = PITCH_INT_BITS + PITCH_FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        START,
        WAIT
    } sched_state_t;

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO with registered read data. A pop loads rd_data on the
// clock edge, so the popped word is visible the cycle after the pop.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   flush          : empty the FIFO (wins over push/pop)
//   push/push_data : write strobe and data
//   pop            : read strobe (ignored while empty)
//   rd_data        : registered read data
//   full, empty    : occupancy status
// ---------------------------------------------------------------------------
module sample_fifo #(
    parameter int SIG_WIDTH = 9,
    parameter int DEPTH     = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 flush,
    input  logic                 push,
    input  logic [SIG_WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [SIG_WIDTH-1:0] rd_data,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(DEPTH);

    logic [SIG_WIDTH-1:0] mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage array has no reset; pointers alone define valid content,
    // and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk_in) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_data <= '0;
        end else if (do_pop && !flush) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: rtl/pitch_frame_scheduler.sv
// ---------------------------------------------------------------------------
// pitch_frame_scheduler
// Frame sequencer in front of the YIN pitch detector. Buffers the incoming
// sample stream while the detector is busy, forwards samples in order,
// fires the detector start on a window/hop cadence, registers each frame's
// pitch result and supervises the detector with a timeout/reset pulse.
// Ports:
//   clk_in, rst_in          : clock, synchronous active-high reset
//   enable_in               : run enable; low forces IDLE and clears flags
//   sig_in, sig_in_valid    : audio sample stream
//   det_sig_out/_valid_out  : samples forwarded to the detector
//   det_start_out           : one-cycle detector start
//   det_rst_out             : one-cycle detector reset on timeout
//   det_f_in, det_f_valid_in: detector pitch result
//   pitch_out/_valid_out    : registered pitch and strobe
//   busy_out                : high in START and WAIT
//   overflow_out            : sticky, a sample was dropped
//   timeout_out             : sticky, the detector timed out
// Build option: define PITCH_HOLD_EN to bridge up to HOLD_FRAMES zero
// results with the last nonzero pitch.
// ---------------------------------------------------------------------------
module pitch_frame_scheduler
    import pitch_sched_pkg::*;
#(
    parameter int SIG_WIDTH      = 9,
    parameter int WIDTH          = PITCH_WIDTH,
    parameter int WINDOW_SIZE    = 500,
    parameter int HOP_SIZE       = 250,
    parameter int FIFO_DEPTH     = 64,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int HOLD_FRAMES    = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 enable_in,
    input  logic [SIG_WIDTH-1:0] sig_in,
    input  logic                 sig_in_valid,
    output logic [SIG_WIDTH-1:0] det_sig_out,
    output logic                 det_sig_valid_out,
    output logic                 det_start_out,
    output logic                 det_rst_out,
    input  logic [WIDTH-1:0]     det_f_in,
    input  logic                 det_f_valid_in,
    output logic [WIDTH-1:0]     pitch_out,
    output logic                 pitch_valid_out,
    output logic                 busy_out,
    output logic                 overflow_out,
    output logic                 timeout_out
);

    localparam int FWD_W  = $clog2(WINDOW_SIZE + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FWD_W-1:0]  WINDOW_T  = FWD_W'(WINDOW_SIZE);
    localparam logic [FWD_W-1:0]  HOP_T     = FWD_W'(HOP_SIZE);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    sched_state_t      state;
    sched_state_t      next_state;
    logic [FWD_W-1:0]  fwd_cnt;
    logic [FWD_W-1:0]  target;
    logic              first;
    logic [WAIT_W-1:0] wait_cnt;

    logic fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic result_take, timeout_hit, overflow_hit;
    logic [WIDTH-1:0] result_word;

    assign target       = first ? WINDOW_T : HOP_T;
    assign fifo_flush   = (state == IDLE) || !enable_in;
    assign fifo_push    = sig_in_valid && (state != IDLE);
    assign fifo_pop     = enable_in && (state == RUN) && !fifo_empty && (fwd_cnt < target);
    assign overflow_hit = fifo_push && fifo_full && !fifo_pop;
    assign result_take  = enable_in && (state == WAIT) && det_f_valid_in;
    // A result arriving on the final WAIT cycle wins over the timeout.
    assign timeout_hit  = enable_in && (state == WAIT) && !det_f_valid_in &&
                          (wait_cnt == WAIT_LAST);

    sample_fifo #(
        .SIG_WIDTH (SIG_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (sig_in),
        .pop       (fifo_pop),
        .rd_data   (det_sig_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        next_state    = state;
        det_start_out = 1'b0;
        busy_out      = 1'b0;
        if (!enable_in) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:  next_state = RUN;
                // fwd_cnt reaches target the cycle the last sample is on the
                // output, so START follows with det_sig_valid_out already low.
                RUN:   if (fwd_cnt == target) next_state = START;
                START: next_state = WAIT;
                WAIT:  if (result_take || timeout_hit) next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
        if (state == START) det_start_out = 1'b1;
        if (state == START || state == WAIT) busy_out = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= IDLE;
            fwd_cnt           <= '0;
            first             <= 1'b1;
            wait_cnt          <= '0;
            det_sig_valid_out <= 1'b0;
            det_rst_out       <= 1'b0;
            pitch_out         <= '0;
            pitch_valid_out   <= 1'b0;
            overflow_out      <= 1'b0;
            timeout_out       <= 1'b0;
        end else begin
            state             <= next_state;
            det_sig_valid_out <= fifo_pop;
            det_rst_out       <= timeout_hit;
            pitch_valid_out   <= result_take || timeout_hit;
            if (result_take)      pitch_out <= result_word;
            else if (timeout_hit) pitch_out <= '0;

            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;

            if (fifo_flush) begin
                fwd_cnt      <= '0;
                first        <= 1'b1;
                overflow_out <= 1'b0;
                timeout_out  <= 1'b0;
            end else begin
                if (fifo_pop) fwd_cnt <= fwd_cnt + 1'b1;
                if (state == START) begin
                    fwd_cnt <= '0;
                    first   <= 1'b0;
                end
                // A timed-out detector restarts from a full window.
                if (timeout_hit) begin
                    first       <= 1'b1;
                    timeout_out <= 1'b1;
                end
                if (overflow_hit) overflow_out <= 1'b1;
            end
        end
    end

`ifdef PITCH_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 2);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_FRAMES);

    logic [WIDTH-1:0]  hold_reg;
    logic [HOLD_W-1:0] zero_cnt;

    always_comb begin
        if (det_f_in != '0)             result_word = det_f_in;
        else if (zero_cnt < HOLD_LIMIT) result_word = hold_reg;
        else                            result_word = '0;
    end

    // Only detector results touch the hold state; timeouts bypass it.
    always_ff @(posedge clk_in) begin
        if (rst_in || !enable_in) begin
            hold_reg <= '0;
            zero_cnt <= '0;
        end else if (result_take) begin
            if (det_f_in != '0) begin
                hold_reg <= det_f_in;
                zero_cnt <= '0;
            end else if (zero_cnt < HOLD_LIMIT) begin
                zero_cnt <= zero_cnt + 1'b1;
            end
        end
    end
`else
    assign result_word = det_f_in;
`endif

endmodule
